// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state type and default bus widths
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
endpackage

// File: rtl/apb_main_sys_if.sv
// apb_main_sys_if: request side of the subsystem (direction, address, data in; read data out)
interface apb_main_sys_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
);
  logic              pwrite;
  logic [ADDR_W-1:0] paddressi;
  logic [DATA_W-1:0] pdatai;
  logic [DATA_W-1:0] prdata;
  modport master (output pwrite, paddressi, pdatai, input prdata);
  modport slave  (input pwrite, paddressi, pdatai, output prdata);
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: zero-wait-state APB register memory with a registered read-data port
module apb_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata
);
  localparam int IW = $clog2(MEM_DEPTH);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [IW-1:0]     idx;
  logic              unused_hi;
  assign idx       = paddr[IW-1:0];
  // upper address bits alias onto the same words
  assign unused_hi = ^paddr[ADDR_W-1:IW];
  assign pready    = psel & penable;
  always_ff @(posedge pclk)
    if (prst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      prdata <= '0;
    end else if (psel && penable && pwrite) mem[idx] <= pwdata;
    else if (psel && penable) prdata <= mem[idx];
endmodule

// File: rtl/apb_main_sys.sv
// apb_main_sys: free-running APB master FSM feeding an internal register-memory slave
module apb_main_sys
  import apb_pkg::*;
#(
  parameter int ADDR_W    = APB_ADDR_W,
  parameter int DATA_W    = APB_DATA_W,
  parameter int MEM_DEPTH = 16
) (
  input logic           pclk,
  input logic           prst,
  apb_main_sys_if.slave bus
);
  apb_state_t        state;
  logic              psel, penable, pwr, pready;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  // request is captured only on entry to SETUP; ACCESS keeps it frozen
  always_ff @(posedge pclk)
    if (prst) begin
      state   <= IDLE;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwr     <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else if (state == SETUP) begin
      state   <= ACCESS;
      penable <= 1'b1;
    end else if (state == IDLE || pready) begin
      state   <= SETUP;
      psel    <= 1'b1;
      penable <= 1'b0;
      pwr     <= bus.pwrite;
      paddr   <= bus.paddressi;
      pwdata  <= bus.pdatai;
    end
  apb_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) u_mem (
    .pclk    (pclk),
    .prst    (prst),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwr),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pready  (pready),
    .prdata  (bus.prdata)
  );
endmodule

// File: tb/tb_apb_main_sys.sv
// tb_apb_main_sys: directed and randomized transfers checked against a transaction-level memory model
module tb_apb_main_sys;
  logic        pclk = 1'b0;
  logic        prst = 1'b1;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mmem [16];
  logic [31:0] mprd;
  logic        pv, pw;
  logic [31:0] pa, pd;

  apb_main_sys_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_main_sys #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(16)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mmem[i] = '0;
    mprd = '0;
    pv   = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    prst = 1'b1;
    repeat (n) @(posedge pclk);
    model_clear();
    @(negedge pclk);
    prst = 1'b0;
  endtask

  // One transfer slot: the previous transfer completes and this one is captured at the
  // first edge; returns on the falling edge inside ACCESS.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic scramble);
    bus.pwrite    = w;
    bus.paddressi = a;
    bus.pdatai    = d;
    @(posedge pclk);
    if (pv) begin
      if (pw) mmem[pa[3:0]] = pd;
      else mprd = mmem[pa[3:0]];
    end
    pv = 1'b1;
    pw = w;
    pa = a;
    pd = d;
    @(posedge pclk);
    if (scramble) begin
      #1;
      bus.pwrite    = ~w;
      bus.paddressi = $urandom;
      bus.pdatai    = $urandom;
    end
    @(negedge pclk);
  endtask

  task automatic test_reset();
    prst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      tests++;
      if (bus.prdata !== 32'h0) begin
        fails++;
        $display("FAIL reset_prdata cycle %0d: got %h expected 00000000", i, bus.prdata);
      end
    end
    model_clear();
    prst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp [4];
    exp[0] = 32'd0; exp[1] = 32'd0; exp[2] = 32'd1; exp[3] = 32'd2;
    for (int i = 0; i < 3; i++) xfer(1'b1, i, i, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, (i < 3) ? i : 0, 32'h0, 1'b0);
      tests++;
      if (bus.prdata !== exp[i]) begin
        fails++;
        $display("FAIL basic_read step %0d: got %h expected %h", i, bus.prdata, exp[i]);
      end
    end
  endtask

  task automatic test_raw();
    xfer(1'b1, 32'd3, 32'hDEADBEEF, 1'b0);
    xfer(1'b0, 32'd3, 32'h0, 1'b0);
    xfer(1'b0, 32'd0, 32'h0, 1'b0);
    tests++;
    if (bus.prdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL read_after_write: got %h expected deadbeef", bus.prdata);
    end
  endtask

  task automatic test_alias();
    xfer(1'b1, 32'd16, 32'h5A, 1'b0);
    xfer(1'b0, 32'd0, 32'h0, 1'b0);
    xfer(1'b0, 32'd5, 32'h0, 1'b0);
    tests++;
    if (bus.prdata !== 32'h5A) begin
      fails++;
      $display("FAIL alias_16_to_0: got %h expected 0000005a", bus.prdata);
    end
  endtask

  task automatic test_unwritten();
    xfer(1'b1, 32'd7, 32'hFFFF, 1'b0);
    xfer(1'b0, 32'd7, 32'h0, 1'b0);
    apply_reset(2);
    xfer(1'b0, 32'd7, 32'h0, 1'b0);
    xfer(1'b0, 32'd7, 32'h0, 1'b0);
    tests++;
    if (bus.prdata !== 32'h0) begin
      fails++;
      $display("FAIL unwritten_after_reset: got %h expected 00000000", bus.prdata);
    end
  endtask

  task automatic test_reset_mid();
    xfer(1'b1, 32'd2, 32'h999, 1'b0);
    xfer(1'b0, 32'd2, 32'h0, 1'b0);
    xfer(1'b1, 32'd2, 32'h1234, 1'b0);
    tests++;
    if (bus.prdata !== 32'h999) begin
      fails++;
      $display("FAIL pre_reset_read: got %h expected 00000999", bus.prdata);
    end
    prst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge pclk);
      @(negedge pclk);
      tests++;
      if (bus.prdata !== 32'h0) begin
        fails++;
        $display("FAIL mid_reset_prdata cycle %0d: got %h expected 00000000", i, bus.prdata);
      end
    end
    model_clear();
    prst = 1'b0;
    xfer(1'b0, 32'd2, 32'h0, 1'b0);
    xfer(1'b0, 32'd0, 32'h0, 1'b0);
    tests++;
    if (bus.prdata !== 32'h0) begin
      fails++;
      $display("FAIL aborted_write: got %h expected 00000000", bus.prdata);
    end
  endtask

  task automatic test_mid_toggle();
    xfer(1'b1, 32'd9, 32'hCAFE, 1'b1);
    xfer(1'b0, 32'd9, 32'h0, 1'b1);
    xfer(1'b0, 32'd0, 32'h0, 1'b0);
    tests++;
    if (bus.prdata !== 32'hCAFE) begin
      fails++;
      $display("FAIL access_toggle_ignored: got %h expected 0000cafe", bus.prdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      tests++;
      if (bus.prdata !== mprd) begin
        fails++;
        $display("FAIL random_xfer %0d: got %h expected %h", i, bus.prdata, mprd);
      end
    end
    for (int i = 0; i < 16; i++) begin
      xfer(1'b0, i, 32'h0, 1'b0);
      tests++;
      if (bus.prdata !== mprd) begin
        fails++;
        $display("FAIL random_sweep %0d: got %h expected %h", i, bus.prdata, mprd);
      end
    end
  endtask

  initial begin
    bus.pwrite    = 1'b0;
    bus.paddressi = '0;
    bus.pdatai    = '0;
    model_clear();
    @(negedge pclk);
    test_reset();
    test_basic();
    test_raw();
    test_alias();
    test_unwritten();
    test_reset_mid();
    test_mid_toggle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
